// File: rtl/clock_divide_nch.sv
// Multi-channel programmable clock divider. Each channel produces a square
// wave and a start-of-period tick, and accepts divisor updates at period boundaries.
module clock_divide_nch #(
    parameter int unsigned CH      = 4,
    parameter int unsigned W       = 24,
    parameter int unsigned DEF_DIV = 120000,
    parameter int unsigned CW      = 2
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic [CH-1:0] ch_en,
    input  logic          sync,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [W-1:0]  wr_div,
    output logic          wr_ack,
    output logic [CH-1:0] pending,
    output logic [CH-1:0] clk_out,
    output logic [CH-1:0] tick
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic [CW:0] CH_LIM = (CW+1)'(CH);

    ch_state_e            state_q [CH];
    ch_state_e            state_d [CH];
    logic [CH-1:0][W-1:0] div_q, div_d;
    logic [CH-1:0][W-1:0] pdiv_q, pdiv_d;
    logic [CH-1:0][W-1:0] cnt_q, cnt_d;
    logic [CH-1:0]        pend_q, pend_d;
    logic [CH-1:0]        clk_q, clk_d;
    logic [CH-1:0]        tick_q, tick_d;
    logic                 wr_ack_q, wr_ack_d;

    logic                 wr_ok;
    logic [CH-1:0]        wsel;
    logic [CH-1:0][W-1:0] idle_div;
    logic [CH-1:0][W-1:0] next_div;
    logic [CH-1:0][W-1:0] cnt_inc;

    assign wr_ok = wr_en && ({1'b0, wr_ch} < CH_LIM);

    always_comb begin
        wr_ack_d = wr_ok;
        for (int unsigned i = 0; i < CH; i++) begin
            wsel[i]     = wr_ok && (wr_ch == CW'(i));
            idle_div[i] = wsel[i] ? wr_div : div_q[i];
            // A same-cycle write outranks the older pending value.
            next_div[i] = wsel[i] ? wr_div : (pend_q[i] ? pdiv_q[i] : div_q[i]);
            cnt_inc[i]  = cnt_q[i] + W'(1);

            state_d[i] = state_q[i];
            div_d[i]   = div_q[i];
            pdiv_d[i]  = pdiv_q[i];
            cnt_d[i]   = cnt_q[i];
            pend_d[i]  = pend_q[i];
            clk_d[i]   = 1'b0;
            tick_d[i]  = 1'b0;

            case (state_q[i])
                ST_IDLE: begin
                    cnt_d[i] = '0;
                    div_d[i] = idle_div[i];
                    if (ch_en[i] && (idle_div[i] != '0)) begin
                        state_d[i] = ST_RUN;
                        tick_d[i]  = 1'b1;
                        clk_d[i]   = (idle_div[i] >= W'(2));
                    end
                end
                ST_RUN: begin
                    if (!ch_en[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                        div_d[i]   = next_div[i];
                        pend_d[i]  = 1'b0;
                    end else if (sync || (cnt_q[i] == div_q[i] - W'(1))) begin
                        div_d[i]  = next_div[i];
                        pend_d[i] = 1'b0;
                        cnt_d[i]  = '0;
                        if (next_div[i] == '0) begin
                            state_d[i] = ST_IDLE;
                        end else begin
                            tick_d[i] = 1'b1;
                            clk_d[i]  = (next_div[i] >= W'(2));
                        end
                    end else begin
                        cnt_d[i] = cnt_inc[i];
                        clk_d[i] = (cnt_inc[i] < (div_q[i] >> 1));
                        if (wsel[i]) begin
                            pdiv_d[i] = wr_div;
                            pend_d[i] = 1'b1;
                        end
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int unsigned i = 0; i < CH; i++) begin
                state_q[i] <= ST_IDLE;
                div_q[i]   <= W'(DEF_DIV);
                pdiv_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
            pend_q   <= '0;
            clk_q    <= '0;
            tick_q   <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
            end
            div_q    <= div_d;
            pdiv_q   <= pdiv_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    assign wr_ack  = wr_ack_q;
    assign pending = pend_q;
    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divide_nch.sv
// Self-checking bench for clock_divide_nch: directed scenarios plus random
// traffic compared against a phase-from-elapsed-time reference model.
module tb_clock_divide_nch;

    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int DEFD = 10;
    localparam int SW   = 3;

    logic            clk_in = 1'b0;
    logic            rst;
    logic [NCH-1:0]  ch_en;
    logic            sync;
    logic            wr_en;
    logic [SW-1:0]   wr_ch;
    logic [DW-1:0]   wr_div;
    logic            wr_ack;
    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  tick;

    clock_divide_nch #(
        .CH      (NCH),
        .W       (DW),
        .DEF_DIV (DEFD),
        .CW      (SW)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .ch_en   (ch_en),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_ack  (wr_ack),
        .pending (pending),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase is derived from edges elapsed since the last phase 0.
    int unsigned cyc = 0;
    int unsigned m_t0   [NCH];
    int          m_d    [NCH];
    int          m_p    [NCH];
    bit          m_pend [NCH];
    bit          m_run  [NCH];
    logic [NCH-1:0] exp_clk, exp_tick, exp_pend;
    logic           exp_ack;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_edge();
        bit sel;
        int nd;
        int ph;
        cyc++;
        exp_ack = !rst && wr_en && (int'(wr_ch) < NCH);
        for (int c = 0; c < NCH; c++) begin
            sel = exp_ack && (int'(wr_ch) == c);
            if (rst) begin
                m_d[c] = DEFD; m_p[c] = 0; m_pend[c] = 0; m_run[c] = 0;
            end else if (!m_run[c]) begin
                if (sel) m_d[c] = int'(wr_div);
                if (ch_en[c] && m_d[c] != 0) begin
                    m_run[c] = 1; m_t0[c] = cyc;
                end
            end else begin
                nd = sel ? int'(wr_div) : (m_pend[c] ? m_p[c] : m_d[c]);
                if (!ch_en[c]) begin
                    m_d[c] = nd; m_pend[c] = 0; m_run[c] = 0;
                end else if (sync || ((cyc - m_t0[c]) % m_d[c]) == 0) begin
                    m_d[c] = nd; m_pend[c] = 0; m_t0[c] = cyc;
                    if (nd == 0) m_run[c] = 0;
                end else if (sel) begin
                    m_p[c] = int'(wr_div); m_pend[c] = 1;
                end
            end
            ph = m_run[c] ? int'((cyc - m_t0[c]) % m_d[c]) : 0;
            exp_tick[c] = m_run[c] && (ph == 0);
            exp_clk[c]  = m_run[c] && (ph < m_d[c] / 2);
            exp_pend[c] = m_pend[c];
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        chk("clk_out", clk_out, exp_clk);
        chk("tick", tick, exp_tick);
        chk("pending", pending, exp_pend);
        chk("wr_ack", wr_ack, exp_ack);
    endtask

    task automatic write(input int c, input int d);
        wr_en = 1'b1; wr_ch = SW'(c); wr_div = DW'(d);
        step();
        wr_en = 1'b0;
    endtask

    logic [7:0] pat_clk  = 8'b0011_0011;
    logic [7:0] pat_tick = 8'b0001_0001;
    int hi, tk, cz;
    bit found;
    int idx;

    initial begin
        rst = 1'b1; ch_en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        step();
        step();
        chk("rst_outputs", {clk_out, tick, pending, wr_ack}, '0);
        rst = 1'b0;

        // D=4 on idle ch0, then enable.
        write(0, 4);
        chk("ack_after_wr", wr_ack, 1);
        chk("idle_no_pending", pending[0], 0);
        ch_en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("d4_clk", clk_out[0], pat_clk[k]);
            chk("d4_tick", tick[0], pat_tick[k]);
        end

        // D=5 on ch1, D=1 on ch2.
        write(1, 5);
        write(2, 1);
        ch_en[2:1] = 2'b11;
        step();
        hi = 0; tk = 0; cz = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            hi += int'(clk_out[1]);
            tk += int'(tick[2]);
            cz += int'(clk_out[2]);
        end
        chk("d5_high_cycles", hi, 4);
        chk("d1_ticks", tk, 10);
        chk("d1_clk_low", cz, 0);

        // Write 6 to running ch0 at cnt=1.
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            step();
            if (tick[0]) found = 1;
        end
        chk("wait_tick0", found, 1);
        step();
        write(0, 6);
        chk("pend_set", pending[0], 1);
        step();
        chk("pend_held", pending[0], 1);
        step();
        chk("wrap_tick", tick[0], 1);
        chk("wrap_pend_clr", pending[0], 0);
        hi = int'(clk_out[0]); tk = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            hi += int'(clk_out[0]);
            tk += int'(tick[0]);
        end
        chk("d6_high_cycles", hi, 3);
        chk("d6_one_tick", tk, 1);

        // ch0 D=4, ch1 D=6, then sync.
        write(0, 4);
        write(1, 6);
        for (int k = 0; k < 13; k++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_ticks", tick[1:0], 2'b11);
        chk("sync_clk", clk_out[1:0], 2'b11);
        step();
        chk("sync_ph1_tick", tick[1:0], 2'b00);

        // Out-of-range channel select.
        wr_en = 1'b1; wr_ch = SW'(NCH); wr_div = 8'd2;
        step();
        wr_en = 1'b0;
        chk("oor_no_ack", wr_ack, 0);
        chk("oor_no_pend", pending, 0);

        // Write 0 to running ch1 stops it at the boundary.
        write(1, 0);
        for (int k = 0; k < 8; k++) step();
        chk("stop_clk", clk_out[1], 0);
        chk("stop_tick", tick[1], 0);

        // Reset mid-period, then restart at DEF_DIV.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_outputs", {clk_out, tick, pending, wr_ack}, '0);
        step();
        chk("restart_tick", tick[0], 1);
        chk("restart_clk", clk_out[0], 1);
        hi = 1;
        for (int k = 0; k < 9; k++) begin
            step();
            hi += int'(clk_out[0]);
        end
        chk("def_div_high", hi, DEFD / 2);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            rst    = ($urandom_range(0, 249) == 0);
            sync   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 14) == 0) begin
                idx = int'($urandom_range(0, NCH - 1));
                ch_en[idx] = ~ch_en[idx];
            end
            wr_en  = ($urandom_range(0, 4) == 0);
            wr_ch  = SW'($urandom_range(0, NCH + 1));
            wr_div = DW'($urandom_range(0, 9));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
